// File: rtl/sar_dac_responder_if.sv
// Purpose: trial handshake bundle between a SAR controller (master) and the
//          DAC/plant responder (slave).
// Signals: req/code/target  master -> slave, trial request and operands
//          busy/ack          slave -> master, trial status and one-cycle done pulse
//          y/above/err       slave -> master, trial result, valid with ack
interface sar_dac_responder_if #(
   parameter int unsigned CODE_W = 4,
   parameter int unsigned OUT_W  = 10
);
   logic              req;
   logic [CODE_W-1:0] code;
   logic [OUT_W-1:0]  target;
   logic              busy;
   logic              ack;
   logic [OUT_W-1:0]  y;
   logic              above;
   logic [OUT_W-1:0]  err;

   modport master (
      output req, code, target,
      input  busy, ack, y, above, err
   );

   modport slave (
      input  req, code, target,
      output busy, ack, y, above, err
   );
endinterface

// File: rtl/sar_dac_responder.sv
// Purpose: DAC/plant model answering a SAR controller. Each trial computes
//          y = OFFSET - STEP*code with a bit-serial shift-add, then reports y,
//          whether y is above the clipped target, and |y - clipped target|.
// Ports:   clk    clock, rising edge
//          rst_n  asynchronous reset, active low
//          bus    slave side of sar_dac_responder_if (req/code/target in,
//                 busy/ack/y/above/err out)
module sar_dac_responder #(
   parameter int unsigned CODE_W = 4,
   parameter int unsigned OUT_W  = 10,
   parameter int unsigned OFFSET = 1000,
   parameter int unsigned STEP   = 30
) (
   input logic                clk,
   input logic                rst_n,
   sar_dac_responder_if.slave bus
);

   localparam int unsigned CNT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam logic [OUT_W-1:0] TGT_HI = OUT_W'(OFFSET);
   localparam logic [OUT_W-1:0] TGT_LO = OUT_W'(OFFSET - STEP * ((1 << CODE_W) - 1));
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CODE_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      CMP  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [OUT_W-1:0]  tgt_q, tgt_d;
   logic [OUT_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [OUT_W-1:0]  y_q, y_d;
   logic              above_q, above_d;
   logic [OUT_W-1:0]  err_q, err_d;
   logic              ack_q, ack_d;
   logic [OUT_W-1:0]  y_c;

   // DAC output for the accumulated product; cannot underflow for legal parameters
   assign y_c = TGT_HI - acc_q;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         code_q  <= '0;
         tgt_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
         above_q <= 1'b0;
         err_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         tgt_q   <= tgt_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         above_q <= above_d;
         err_q   <= err_d;
         ack_q   <= ack_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      tgt_d   = tgt_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      above_d = above_q;
      err_d   = err_q;
      ack_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req) begin
               code_d = bus.code;
               // Clip target into the reachable output range
               if (bus.target < TGT_LO) begin
                  tgt_d = TGT_LO;
               end else if (bus.target > TGT_HI) begin
                  tgt_d = TGT_HI;
               end else begin
                  tgt_d = bus.target;
               end
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            // One code bit per cycle, LSB first
            if (code_q[cnt_q]) begin
               acc_d = acc_q + (OUT_W'(STEP) << cnt_q);
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = CMP;
            end
         end
         CMP: begin
            y_d     = y_c;
            above_d = (y_c > tgt_q);
            err_d   = (y_c > tgt_q) ? (y_c - tgt_q) : (tgt_q - y_c);
            ack_d   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy  = (state_q != IDLE);
   assign bus.ack   = ack_q;
   assign bus.y     = y_q;
   assign bus.above = above_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_sar_dac_responder.sv
// Purpose: directed self-checking bench for sar_dac_responder.
module tb_sar_dac_responder;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   sar_dac_responder_if #(.CODE_W(4), .OUT_W(10)) bus ();

   sar_dac_responder #(
      .CODE_W(4),
      .OUT_W (10),
      .OFFSET(1000),
      .STEP  (30)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One trial: req for one cycle, then wait for ack and check latency, busy and results
   task automatic run_trial(input logic [3:0] c, input logic [9:0] t, input logic [9:0] ey,
                            input logic ea, input logic [9:0] ee, input string nm);
      int n;
      int nb;
      @(negedge clk);
      bus.req    = 1'b1;
      bus.code   = c;
      bus.target = t;
      @(negedge clk);
      bus.req = 1'b0;
      n  = 1;
      nb = 0;
      while (bus.ack !== 1'b1 && n < 20) begin
         nb += int'(bus.busy);
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, expected 6", nm, n);
      end
      checks++;
      if (nb != 5) begin
         errors++;
         $display("FAIL %s busy cycles: got %0d, expected 5", nm, nb);
      end
      checks++;
      if (bus.y !== ey || bus.above !== ea || bus.err !== ee) begin
         errors++;
         $display("FAIL %s result: got y=%0d above=%0b err=%0d, expected y=%0d above=%0b err=%0d",
                  nm, bus.y, bus.above, bus.err, ey, ea, ee);
      end
      @(negedge clk);
      checks++;
      if (bus.ack !== 1'b0) begin
         errors++;
         $display("FAIL %s ack pulse: got ack=%0b one cycle later, expected 0", nm, bus.ack);
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      bus.req    = 1'b0;
      bus.code   = '0;
      bus.target = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.ack, bus.y, bus.above, bus.err} !== 23'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%0b ack=%0b y=%0d above=%0b err=%0d, expected all 0",
                  bus.busy, bus.ack, bus.y, bus.above, bus.err);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [9:0] y_hold;
      run_trial(4'd11, 10'd630, 10'd670, 1'b1, 10'd40, "code11_t630");
      y_hold = bus.y;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.y !== 10'd670 || bus.err !== 10'd40 || bus.above !== 1'b1) begin
         errors++;
         $display("FAIL hold: got y=%0d above=%0b err=%0d, expected y=670 above=1 err=40 (was %0d)",
                  bus.y, bus.above, bus.err, y_hold);
      end
      run_trial(4'd0,  10'd1000, 10'd1000, 1'b0, 10'd0,   "code0_t1000");
      run_trial(4'd15, 10'd1000, 10'd550,  1'b0, 10'd450, "code15_t1000");
   endtask

   task automatic test_clip();
      run_trial(4'd15, 10'd400,  10'd550, 1'b0, 10'd0,   "clip_low");
      run_trial(4'd12, 10'd700,  10'd640, 1'b0, 10'd60,  "code12_t700");
      run_trial(4'd0,  10'd1023, 10'd1000, 1'b0, 10'd0,  "clip_high");
   endtask

   task automatic test_sweep();
      int ey;
      for (int c = 0; c < 16; c++) begin
         ey = 1000 - 30 * c;
         run_trial(4'(c), 10'd780, 10'(ey), (c <= 7), 10'((ey > 780) ? ey - 780 : 780 - ey),
                   $sformatf("sweep_code%0d", c));
      end
   endtask

   task automatic test_ignore_req();
      int acks;
      @(negedge clk);
      bus.req    = 1'b1;
      bus.code   = 4'd11;
      bus.target = 10'd630;
      @(negedge clk);
      bus.req = 1'b0;
      @(negedge clk);
      bus.req    = 1'b1;
      bus.code   = 4'd0;
      bus.target = 10'd1000;
      @(negedge clk);
      bus.req = 1'b0;
      acks = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus.ack === 1'b1) begin
            acks++;
            checks++;
            if (bus.y !== 10'd670 || bus.above !== 1'b1 || bus.err !== 10'd40) begin
               errors++;
               $display("FAIL ignore_req result: got y=%0d above=%0b err=%0d, expected 670/1/40",
                        bus.y, bus.above, bus.err);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL ignore_req acks: got %0d, expected 1", acks);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      bus.req    = 1'b1;
      bus.code   = 4'd2;
      bus.target = 10'd1000;
      n = 1;
      @(negedge clk);
      while (bus.ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 6 || bus.y !== 10'd940 || bus.above !== 1'b0 || bus.err !== 10'd60) begin
         errors++;
         $display("FAIL b2b first: got n=%0d y=%0d above=%0b err=%0d, expected 6/940/0/60",
                  n, bus.y, bus.above, bus.err);
      end
      // Still requesting in the ack cycle: new operands must be taken with no gap
      bus.code   = 4'd4;
      bus.target = 10'd800;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bus.ack !== 1'b0) begin
         errors++;
         $display("FAIL b2b accept: got busy=%0b ack=%0b, expected busy=1 ack=0", bus.busy, bus.ack);
      end
      bus.req    = 1'b0;
      bus.code   = 4'd9;
      bus.target = 10'd550;
      n = 1;
      while (bus.ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 6 || bus.y !== 10'd880 || bus.above !== 1'b1 || bus.err !== 10'd80) begin
         errors++;
         $display("FAIL b2b second: got n=%0d y=%0d above=%0b err=%0d, expected 6/880/1/80",
                  n, bus.y, bus.above, bus.err);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int acks;
      @(negedge clk);
      bus.req    = 1'b1;
      bus.code   = 4'd5;
      bus.target = 10'd900;
      @(negedge clk);
      bus.req = 1'b0;
      repeat (2) @(negedge clk);
      // Two MUL edges taken, cnt is now 2
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.ack, bus.y, bus.above, bus.err} !== 23'd0) begin
         errors++;
         $display("FAIL reset_mid: got busy=%0b ack=%0b y=%0d above=%0b err=%0d, expected all 0",
                  bus.busy, bus.ack, bus.y, bus.above, bus.err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      acks  = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.ack === 1'b1) acks++;
      end
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL reset_mid ack: got %0d acks after abort, expected 0", acks);
      end
      run_trial(4'd6, 10'd900, 10'd820, 1'b0, 10'd80, "after_reset");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_clip();
      test_sweep();
      test_ignore_req();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
